// File: rtl/mult_reservation_station.sv
// Reservation station feeding a single multiplier.
// Entries wait for both operands, snooping the common data bus for pending ones.
// Ready entries are dispatched lowest-index first, with one pulse per dispatch.
//
// Handshakes:
//   Issue: a transfer happens on a rising edge where issue_valid_in and
//   issue_ready_out are both high. issue_ready_out does not depend on
//   issue_valid_in.
//
//   Dispatch: mul_valid_out is a one-cycle pulse that the multiplier must take.
//   mul_ready_in only permits a dispatch. No dispatch is started while a pulse
//   is already out, because the multiplier's idle flag reacts one cycle late.
module mult_reservation_station #(
    parameter int DEPTH    = 4,
    parameter int ROB_IX_W = 3
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                flush_in,
    input  logic                issue_valid_in,
    output logic                issue_ready_out,
    input  logic [ROB_IX_W-1:0] issue_rob_ix_in,
    input  logic [31:0]         issue_op1_in,
    input  logic [31:0]         issue_op2_in,
    input  logic                issue_op1_rdy_in,
    input  logic                issue_op2_rdy_in,
    input  logic [ROB_IX_W-1:0] issue_op1_tag_in,
    input  logic [ROB_IX_W-1:0] issue_op2_tag_in,
    input  logic                cdb_valid_in,
    input  logic [ROB_IX_W-1:0] cdb_rob_ix_in,
    input  logic [31:0]         cdb_data_in,
    input  logic                mul_ready_in,
    output logic                mul_valid_out,
    output logic [31:0]         mul_rval1_out,
    output logic [31:0]         mul_rval2_out,
    output logic [ROB_IX_W-1:0] mul_rob_ix_out
);
    localparam int IX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]    busy_q;
    logic [DEPTH-1:0]    op1_rdy_q;
    logic [DEPTH-1:0]    op2_rdy_q;
    logic [ROB_IX_W-1:0] rob_q     [DEPTH];
    logic [ROB_IX_W-1:0] op1_tag_q [DEPTH];
    logic [ROB_IX_W-1:0] op2_tag_q [DEPTH];
    logic [31:0]         op1_val_q [DEPTH];
    logic [31:0]         op2_val_q [DEPTH];

    logic            free_found;
    logic [IX_W-1:0] free_ix;
    logic            elig_found;
    logic [IX_W-1:0] elig_ix;
    logic            do_issue;
    logic            do_disp;
    logic            iss_op1_rdy;
    logic            iss_op2_rdy;
    logic [31:0]     iss_op1_val;
    logic [31:0]     iss_op2_val;

    // Pick the lowest free and lowest eligible entries. The loops run downward,
    // so the last hit is the lowest index. Eligibility uses registered flags
    // only, so an operand captured this cycle makes its entry eligible next cycle.
    always_comb begin
        free_found = 1'b0;
        free_ix    = '0;
        elig_found = 1'b0;
        elig_ix    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_ix    = IX_W'(i);
            end
            if (busy_q[i] && op1_rdy_q[i] && op2_rdy_q[i]) begin
                elig_found = 1'b1;
                elig_ix    = IX_W'(i);
            end
        end
    end

    // Issue acceptance, dispatch decision, and the bus bypass for issuing operands.
    always_comb begin
        issue_ready_out = free_found && !flush_in;
        do_issue        = issue_valid_in && issue_ready_out;
        do_disp         = mul_ready_in && !mul_valid_out && elig_found && !flush_in;
        iss_op1_rdy     = issue_op1_rdy_in ||
                          (cdb_valid_in && (issue_op1_tag_in == cdb_rob_ix_in));
        iss_op2_rdy     = issue_op2_rdy_in ||
                          (cdb_valid_in && (issue_op2_tag_in == cdb_rob_ix_in));
        iss_op1_val     = issue_op1_rdy_in ? issue_op1_in : cdb_data_in;
        iss_op2_val     = issue_op2_rdy_in ? issue_op2_in : cdb_data_in;
    end

    // Entry state and dispatch register: reset, flush, bus snoop, dispatch, issue.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q         <= '0;
            op1_rdy_q      <= '0;
            op2_rdy_q      <= '0;
            mul_valid_out  <= 1'b0;
            mul_rval1_out  <= '0;
            mul_rval2_out  <= '0;
            mul_rob_ix_out <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i]     <= '0;
                op1_tag_q[i] <= '0;
                op2_tag_q[i] <= '0;
                op1_val_q[i] <= '0;
                op2_val_q[i] <= '0;
            end
        end else if (flush_in) begin
            busy_q        <= '0;
            op1_rdy_q     <= '0;
            op2_rdy_q     <= '0;
            mul_valid_out <= 1'b0;
        end else begin
            // Busy entries waiting on an operand capture a matching bus broadcast.
            for (int i = 0; i < DEPTH; i++) begin
                if (busy_q[i] && cdb_valid_in) begin
                    if (!op1_rdy_q[i] && (op1_tag_q[i] == cdb_rob_ix_in)) begin
                        op1_rdy_q[i] <= 1'b1;
                        op1_val_q[i] <= cdb_data_in;
                    end
                    if (!op2_rdy_q[i] && (op2_tag_q[i] == cdb_rob_ix_in)) begin
                        op2_rdy_q[i] <= 1'b1;
                        op2_val_q[i] <= cdb_data_in;
                    end
                end
            end

            mul_valid_out <= do_disp;
            if (do_disp) begin
                mul_rval1_out   <= op1_val_q[elig_ix];
                mul_rval2_out   <= op2_val_q[elig_ix];
                mul_rob_ix_out  <= rob_q[elig_ix];
                busy_q[elig_ix] <= 1'b0;
            end

            // The free entry is never the one being dispatched, so these writes
            // do not collide with the dispatch clear above.
            if (do_issue) begin
                busy_q[free_ix]    <= 1'b1;
                rob_q[free_ix]     <= issue_rob_ix_in;
                op1_rdy_q[free_ix] <= iss_op1_rdy;
                op2_rdy_q[free_ix] <= iss_op2_rdy;
                op1_tag_q[free_ix] <= issue_op1_tag_in;
                op2_tag_q[free_ix] <= issue_op2_tag_in;
                op1_val_q[free_ix] <= iss_op1_val;
                op2_val_q[free_ix] <= iss_op2_val;
            end
        end
    end
endmodule
